// File: rtl/mod_descr_pkg.sv
// Shared constants and types for the 6-bit additive descrambler and its
// matching scrambler. Optional feature macro: DESCR_BYPASS_EN (see top).
package mod_descr_pkg;

   localparam int unsigned DATA_W = 6;
   localparam int unsigned LFSR_W = 7;

   // Seed used whenever an all-zero seed is requested (zero locks the LFSR)
   localparam logic [LFSR_W-1:0] DEF_SEED = 7'h7F;

   // Feedback taps for x^7 + x^6 + 1; TAP_A is also the output bit
   localparam int unsigned TAP_A = 6;
   localparam int unsigned TAP_B = 5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // One Fibonacci step: shift left, feedback enters at bit 0
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B]};
   endfunction

   // Replace an illegal zero seed by the default one
   function automatic logic [LFSR_W-1:0] legal_seed(input logic [LFSR_W-1:0] s);
      return (s == '0) ? DEF_SEED : s;
   endfunction

endpackage

// File: rtl/mod_lfsr_step6.sv
// Combinational six-step LFSR advance: yields the 6-bit keystream for one
// word (first step's output lands in the MSB) and the state after six steps.
// Shared by the descrambler and the matching scrambler.
module mod_lfsr_step6
   import mod_descr_pkg::*;
(
   input  logic [LFSR_W-1:0] state_i,
   output logic [DATA_W-1:0] key_o,
   output logic [LFSR_W-1:0] next_o
);

   logic [LFSR_W-1:0] walk_s;

   // Unroll six LFSR steps, collecting the output bit of each
   always_comb begin
      walk_s = state_i;
      key_o  = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         key_o[DATA_W-1-i] = walk_s[TAP_A];
         walk_s            = lfsr_step(walk_s);
      end
      next_o = walk_s;
   end

endmodule

// File: rtl/mod_xor_descrambler_6b.sv
// Additive descrambler for the ALU 6-bit data path: each accepted word is
// XORed with a 6-bit slice of an x^7+x^6+1 keystream, one registered output
// stage with valid/ready on both sides.
// Optional macro DESCR_BYPASS_EN adds a BYPASS input that passes accepted
// words through unmodified without advancing the LFSR.
module mod_xor_descrambler_6b
   import mod_descr_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              SEED_LD,
   input  logic [LFSR_W-1:0] SEED_IN,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic [7:0]        WORD_CNT,
   output logic              SEED_ERR
`ifdef DESCR_BYPASS_EN
   ,
   input  logic              BYPASS
`endif
);

   state_t            state_q;
   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] out_data_d;
   logic [7:0]        word_cnt_q;
   logic              seed_err_q;

   logic [LFSR_W-1:0] seed_d;
   logic              seed_zero;
   logic [DATA_W-1:0] key;
   logic [LFSR_W-1:0] lfsr_adv;
   logic              in_ready;
   logic              in_fire;
   logic              out_fire;
   logic              bypass_w;

`ifdef DESCR_BYPASS_EN
   assign bypass_w = BYPASS;
`else
   assign bypass_w = 1'b0;
`endif

   mod_lfsr_step6 u_step6 (
      .state_i (lfsr_q),
      .key_o   (key),
      .next_o  (lfsr_adv)
   );

   // Handshake decode, seed sanitising and next word / next LFSR selection
   always_comb begin
      seed_zero  = (SEED_IN == '0);
      seed_d     = legal_seed(SEED_IN);
      in_ready   = (state_q == RUN) & ~SEED_LD & (~out_valid_q | OUT_READY);
      in_fire    = IN_VALID & in_ready;
      out_fire   = out_valid_q & OUT_READY;
      out_data_d = bypass_w ? IN_DATA : (IN_DATA ^ key);
      lfsr_d     = bypass_w ? lfsr_q : lfsr_adv;
   end

   // Control FSM with registered datapath outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         lfsr_q      <= DEF_SEED;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         word_cnt_q  <= '0;
         seed_err_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (SEED_LD) begin
                  lfsr_q     <= seed_d;
                  seed_err_q <= seed_err_q | seed_zero;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               // in_fire is never true while SEED_LD is high, so the two
               // lfsr_q writers below are mutually exclusive; the output
               // drain is kept independent so a reseed does not block it.
               if (SEED_LD) begin
                  lfsr_q     <= seed_d;
                  seed_err_q <= seed_err_q | seed_zero;
               end
               if (in_fire) begin
                  lfsr_q      <= lfsr_d;
                  out_data_q  <= out_data_d;
                  out_valid_q <= 1'b1;
                  word_cnt_q  <= word_cnt_q + 8'd1;
               end else if (out_fire) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign WORD_CNT  = word_cnt_q;
   assign SEED_ERR  = seed_err_q;

`ifndef SYNTHESIS
   // A stalled output word must stay put until the consumer takes it
   a_hold: assert property (@(posedge CLK) disable iff (RST)
      (out_valid_q && !OUT_READY) |=> (out_valid_q && $stable(out_data_q)));

   // Words are only accepted once seeded
   a_ready_run: assert property (@(posedge CLK) disable iff (RST)
      in_ready |-> (state_q == RUN));
`endif

endmodule

// File: tb/tb_mod_xor_descrambler_6b.sv
// Directed, table-driven bench for mod_xor_descrambler_6b with a small
// bit-sequence keystream model (o[t+7] = o[t] ^ o[t+1]).
module tb_mod_xor_descrambler_6b;

   logic       clk = 1'b0;
   logic       rst;
   logic       seed_ld;
   logic [6:0] seed_in;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_data;
   logic [7:0] word_cnt;
   logic       seed_err;
`ifdef DESCR_BYPASS_EN
   logic       bypass;
`endif

   always #5 clk = ~clk;

   mod_xor_descrambler_6b dut (
      .CLK       (clk),
      .RST       (rst),
      .SEED_LD   (seed_ld),
      .SEED_IN   (seed_in),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .IN_DATA   (in_data),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUT_DATA  (out_data),
      .WORD_CNT  (word_cnt),
      .SEED_ERR  (seed_err)
`ifdef DESCR_BYPASS_EN
      ,
      .BYPASS    (bypass)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0] din;
      logic [5:0] dout;
   } vec_t;
   vec_t tbl [5];

   // Keystream model: window m_w[j] holds output bit o[t+j]
   logic       m_w [7];
   logic [7:0] m_cnt;
   logic [5:0] m_last;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic model_seed(input logic [6:0] seed);
      for (int j = 0; j < 7; j++) m_w[j] = seed[6-j];
   endtask

   task automatic model_word(output logic [5:0] key);
      logic nb;
      key = '0;
      for (int i = 0; i < 6; i++) begin
         key[5-i] = m_w[0];
         nb = m_w[0] ^ m_w[1];
         for (int j = 0; j < 6; j++) m_w[j] = m_w[j+1];
         m_w[6] = nb;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one word with OUT_READY high and check it one edge later
   task automatic send_word(input logic [5:0] d);
      logic [5:0] k;
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = 1'b1;
      #1;
      check("in_ready_run", in_ready, 1);
      model_word(k);
      m_cnt  = m_cnt + 8'd1;
      m_last = d ^ k;
      tick;
      check("word_valid", out_valid, 1);
      check("word_data", out_data, m_last);
      check("word_cnt", word_cnt, m_cnt);
   endtask

   task automatic do_seed(input logic [6:0] s);
      seed_ld = 1'b1;
      seed_in = s;
      tick;
      seed_ld = 1'b0;
      model_seed((s == 7'h00) ? 7'h7F : s);
   endtask

   initial begin
      logic [7:0] cnt_before;
      tbl[0] = '{6'h3F, 6'h00};   // key 0x3F
      tbl[1] = '{6'h2A, 6'h0A};   // key 0x20
      tbl[2] = '{6'h00, 6'h10};   // key 0x10
      tbl[3] = '{6'h18, 6'h00};   // key 0x18
      tbl[4] = '{6'h3F, 6'h2B};   // key 0x14

      rst = 1'b1; seed_ld = 1'b0; seed_in = '0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0; m_cnt = '0; m_last = '0;
`ifdef DESCR_BYPASS_EN
      bypass = 1'b0;
`endif
      model_seed(7'h7F);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_seed_err", seed_err, 0);
      check("rst_in_ready", in_ready, 0);

      // IDLE ignores words until seeded
      rst = 1'b0;
      in_valid = 1'b1; in_data = 6'h3F; out_ready = 1'b1;
      #1;
      check("idle_in_ready", in_ready, 0);
      tick;
      check("idle_cnt", word_cnt, 0);
      check("idle_valid", out_valid, 0);
      in_valid = 1'b0;

      // Seed 0x7F and run the hand-computed table back-to-back
      do_seed(7'h7F);
      check("seed_err_clean", seed_err, 0);
      for (int i = 0; i < 5; i++) begin
         logic [5:0] k;
         in_valid = 1'b1; in_data = tbl[i].din; out_ready = 1'b1;
         #1;
         check("tbl_in_ready", in_ready, 1);
         model_word(k);
         m_cnt = m_cnt + 8'd1;
         tick;
         check("tbl_valid", out_valid, 1);
         check("tbl_data", out_data, tbl[i].dout);
         check("tbl_cnt", word_cnt, m_cnt);
      end
      m_last = 6'h2B;

      // Backpressure: five stalled cycles with a word waiting
      in_valid = 1'b1; in_data = 6'h11; out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_in_ready", in_ready, 0);
         tick;
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, m_last);
         check("bp_cnt", word_cnt, m_cnt);
      end
      send_word(6'h11);
      send_word(6'h22);
      send_word(6'h33);
      send_word(6'h04);

      // Zero seed with a word offered the same cycle
      seed_ld = 1'b1; seed_in = 7'h00; in_valid = 1'b1; in_data = 6'h07; out_ready = 1'b1;
      #1;
      check("seedld_in_ready", in_ready, 0);
      tick;
      seed_ld = 1'b0;
      model_seed(7'h7F);
      check("zero_seed_err", seed_err, 1);
      check("seedld_cnt_hold", word_cnt, m_cnt);
      check("seedld_drained", out_valid, 0);
      send_word(6'h07);
      check("zero_seed_word", out_data, 6'h38);

      // Reseed while an output word is stalled: word retained, flag sticky
      in_valid = 1'b0; out_ready = 1'b0;
      do_seed(7'h55);
      check("reseed_keep_valid", out_valid, 1);
      check("reseed_keep_data", out_data, 6'h38);
      check("seed_err_sticky", seed_err, 1);
      check("reseed_cnt", word_cnt, m_cnt);
      send_word(6'h00);
      send_word(6'h2D);

      // 256 words: counter wraps back to its starting value
      cnt_before = m_cnt;
      for (int n = 0; n < 256; n++) send_word(6'($urandom_range(0, 63)));
      check("cnt_wrap", word_cnt, cnt_before);

      // Drain with no new input: valid drops, data holds
      in_valid = 1'b0; out_ready = 1'b1;
      tick;
      check("drain_valid", out_valid, 0);
      check("drain_data", out_data, m_last);

`ifdef DESCR_BYPASS_EN
      bypass = 1'b1; in_valid = 1'b1; in_data = 6'h15; out_ready = 1'b1;
      m_cnt = m_cnt + 8'd1;
      tick;
      check("bypass_data", out_data, 6'h15);
      check("bypass_cnt", word_cnt, m_cnt);
      bypass = 1'b0;
      send_word(6'h2C);
`endif

      // Async reset with a pending output word
      in_valid = 1'b1; in_data = 6'h09; out_ready = 1'b0;
      tick;
      check("pre_rst_valid", out_valid, 1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_data", out_data, 0);
      check("arst_cnt", word_cnt, 0);
      check("arst_seed_err", seed_err, 0);
      check("arst_in_ready", in_ready, 0);
      #1;
      rst = 1'b0;
      m_cnt = '0;
      in_valid = 1'b1; in_data = 6'h3F; out_ready = 1'b1;
      tick;
      tick;
      check("post_rst_cnt", word_cnt, 0);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 0);
      in_valid = 1'b0;
      do_seed(7'h7F);
      send_word(6'h3F);
      check("post_rst_word", out_data, 6'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
